// File: rtl/lc3b_types.sv
// Shared LC-3b types for the MEM stage: the MEM sequencing state, the 16-bit
// machine word, byte-lane enable encodings and the latched access mode.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        IND_RD,
        ACCESS
    } lc3b_mem_state;

    // {hi, lo} lane enables
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

    // Mode bits captured when the op is accepted; ctrl_* is ignored afterwards.
    // The indirect bit is consumed by the IDLE transition and is not kept.
    typedef struct packed {
        logic write;
        logic byte_acc;
    } lc3b_mem_mode;

    // Lane select for the data access: odd byte addresses use the high lane.
    function automatic logic [1:0] lane_enable(input logic byte_acc, input logic a0);
        if (!byte_acc)
            return BE_WORD;
        return a0 ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   inc        : advance by one unless already all-ones
//   clear      : synchronous clear, takes priority over inc
//   count      : current value
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {WIDTH{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for the pipelined LC-3b. Drives the memory handshake for
// loads, stores, byte accesses and LDI/STI (pointer fetch, then data access),
// stalls upstream while an access is outstanding and pulses mem_wb_load when
// the instruction completes.
//   valid_in, ctrl_*      : instruction from EX/MEM
//   mar_in                : address from EX/MEM
//   mem_rdata, mem_resp   : memory return path (mem_resp is a 1-cycle pulse)
//   mem_read/mem_write    : memory requests, held until mem_resp
//   mem_byte_enable       : {hi, lo} lanes
//   mem_address           : word-aligned request address (0 when idle)
//   addr_out              : unaligned effective address for write-back lane select
//   stall, mem_wb_load    : pipeline control
//   stall_count           : saturating count of stalled cycles
module mem_stage_ctrl
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        ctrl_mem_read,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_indirect,
    input  logic        ctrl_byte,
    input  lc3b_word    mar_in,
    input  lc3b_word    mem_rdata,
    input  logic        mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output lc3b_word    mem_address,
    output lc3b_word    addr_out,
    output logic        stall,
    output logic        mem_wb_load,
    output logic [15:0] stall_count
);

    lc3b_mem_state state_q, state_d;
    lc3b_word      addr_q, addr_d;
    lc3b_mem_mode  mode_q, mode_d;
    logic          mem_op;

    assign mem_op   = valid_in & (ctrl_mem_read | ctrl_mem_write);
    assign addr_out = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs are forced low while reset is held so an abandoned access drops
    // its request immediately and nothing leaks to the pipeline.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        mode_d          = mode_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = '0;
        stall           = 1'b0;
        mem_wb_load     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        stall          = 1'b1;
                        addr_d         = mar_in;
                        // read+write together is treated as a write
                        mode_d.write    = ctrl_mem_write;
                        mode_d.byte_acc = ctrl_byte;
                        state_d        = ctrl_indirect ? IND_RD : ACCESS;
                    end else begin
                        mem_wb_load = valid_in;
                    end
                end
                IND_RD: begin
                    mem_read        = 1'b1;
                    mem_byte_enable = BE_WORD;
                    mem_address     = {addr_q[15:1], 1'b0};
                    stall           = 1'b1;
                    if (mem_resp) begin
                        addr_d  = mem_rdata;
                        state_d = ACCESS;
                    end
                end
                ACCESS: begin
                    mem_read        = !mode_q.write;
                    mem_write       = mode_q.write;
                    mem_byte_enable = lane_enable(mode_q.byte_acc, addr_q[0]);
                    mem_address     = {addr_q[15:1], 1'b0};
                    if (mem_resp) begin
                        mem_wb_load = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    sat_counter #(.WIDTH(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clear (1'b0),
        .count (stall_count)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, ctrl_mem_read, ctrl_mem_write, ctrl_indirect, ctrl_byte;
    logic [15:0] mar_in, mem_rdata;
    logic        mem_resp;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address, addr_out, stall_count;
    logic        stall, mem_wb_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .ctrl_mem_read   (ctrl_mem_read),
        .ctrl_mem_write  (ctrl_mem_write),
        .ctrl_indirect   (ctrl_indirect),
        .ctrl_byte       (ctrl_byte),
        .mar_in          (mar_in),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .addr_out        (addr_out),
        .stall           (stall),
        .mem_wb_load     (mem_wb_load),
        .stall_count     (stall_count)
    );

    // Direct access vectors: request fields and hand-computed bus values.
    typedef struct {
        string       name;
        logic        rd, wr, bt;
        logic [15:0] mar;
        int          n;        // ACCESS cycle on which mem_resp arrives
        logic [1:0]  exp_be;
        logic [15:0] exp_addr;
        logic        exp_rd, exp_wr;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; ctrl_mem_read = 0; ctrl_mem_write = 0;
        ctrl_indirect = 0; ctrl_byte = 0; mar_in = 16'hFFFF; mem_resp = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] sc0;
        valid_in = 1; ctrl_mem_read = v.rd; ctrl_mem_write = v.wr;
        ctrl_indirect = 0; ctrl_byte = v.bt; mar_in = v.mar;
        #1;
        sc0 = stall_count;
        chk({v.name, " detect stall"}, {15'd0, stall}, 16'd1);
        chk({v.name, " detect wb"}, {15'd0, mem_wb_load}, 16'd0);
        chk({v.name, " detect addr"}, mem_address, 16'h0000);
        tick();
        idle_inputs();   // later ctrl changes must be ignored
        for (int i = 1; i <= v.n; i++) begin
            mem_resp = (i == v.n);
            #1;
            chk({v.name, " rd"}, {15'd0, mem_read}, {15'd0, v.exp_rd});
            chk({v.name, " wr"}, {15'd0, mem_write}, {15'd0, v.exp_wr});
            chk({v.name, " be"}, {14'd0, mem_byte_enable}, {14'd0, v.exp_be});
            chk({v.name, " addr"}, mem_address, v.exp_addr);
            chk({v.name, " stall"}, {15'd0, stall}, (i == v.n) ? 16'd0 : 16'd1);
            chk({v.name, " wb"}, {15'd0, mem_wb_load}, (i == v.n) ? 16'd1 : 16'd0);
            tick();
            mem_resp = 0;
        end
        #1;
        chk({v.name, " addr_out"}, addr_out, v.mar);
        chk({v.name, " stall_count delta"}, stall_count - sc0, 16'(v.n));
        chk({v.name, " back idle rd"}, {15'd0, mem_read | mem_write}, 16'd0);
    endtask

    initial begin
        vecs[0] = '{"LDR",  1, 0, 0, 16'h3001, 3, 2'b11, 16'h3000, 1, 0};
        vecs[1] = '{"STB",  0, 1, 1, 16'h4005, 1, 2'b10, 16'h4004, 0, 1};
        vecs[2] = '{"LDB",  1, 0, 1, 16'h1234, 2, 2'b01, 16'h1234, 1, 0};
        vecs[3] = '{"RDWR", 1, 1, 0, 16'h0F0F, 2, 2'b11, 16'h0F0E, 0, 1};

        // Reset with a memory op present and mem_resp toggling
        idle_inputs();
        mem_rdata = 16'h0;
        reset = 1;
        valid_in = 1; ctrl_mem_read = 1; mar_in = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            mem_resp = i[0];
            tick();
        end
        chk("rst rd", {15'd0, mem_read}, 16'd0);
        chk("rst wr", {15'd0, mem_write}, 16'd0);
        chk("rst stall", {15'd0, stall}, 16'd0);
        chk("rst wb", {15'd0, mem_wb_load}, 16'd0);
        chk("rst be", {14'd0, mem_byte_enable}, 16'd0);
        chk("rst addr", mem_address, 16'd0);
        chk("rst addr_out", addr_out, 16'd0);
        chk("rst stall_count", stall_count, 16'd0);
        idle_inputs();
        reset = 0;
        #1;
        chk("idle wb", {15'd0, mem_wb_load}, 16'd0);

        // ALU op: same-cycle mem_wb_load, no stall
        valid_in = 1;
        #1;
        chk("alu wb", {15'd0, mem_wb_load}, 16'd1);
        chk("alu stall", {15'd0, stall}, 16'd0);
        chk("alu req", {15'd0, mem_read | mem_write}, 16'd0);
        tick();
        valid_in = 0;
        #1;

        // Stray mem_resp in IDLE has no effect
        mem_resp = 1;
        #1;
        chk("stray resp wb", {15'd0, mem_wb_load}, 16'd0);
        chk("stray resp stall", {15'd0, stall}, 16'd0);
        tick();
        mem_resp = 0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // LDI: pointer at 0x2000 returns 0x5A5B, data read at 0x5A5A
        begin
            logic [15:0] sc0;
            valid_in = 1; ctrl_mem_read = 1; ctrl_indirect = 1; mar_in = 16'h2000;
            #1;
            sc0 = stall_count;
            tick();
            idle_inputs();
            for (int i = 1; i <= 2; i++) begin
                mem_resp = (i == 2);
                mem_rdata = (i == 2) ? 16'h5A5B : 16'hDEAD;
                #1;
                chk("ldi ind rd", {15'd0, mem_read}, 16'd1);
                chk("ldi ind addr", mem_address, 16'h2000);
                chk("ldi ind be", {14'd0, mem_byte_enable}, 16'd3);
                chk("ldi ind stall", {15'd0, stall}, 16'd1);
                chk("ldi ind wb", {15'd0, mem_wb_load}, 16'd0);
                tick();
            end
            mem_resp = 0; mem_rdata = 16'h0;
            #1;
            chk("ldi acc rd", {15'd0, mem_read}, 16'd1);
            chk("ldi acc addr", mem_address, 16'h5A5A);
            chk("ldi acc wb early", {15'd0, mem_wb_load}, 16'd0);
            mem_resp = 1;
            #1;
            chk("ldi acc wb", {15'd0, mem_wb_load}, 16'd1);
            chk("ldi addr_out", addr_out, 16'h5A5B);
            tick();
            mem_resp = 0;
            #1;
            chk("ldi stall_count delta", stall_count - sc0, 16'd3);
            chk("ldi idle", {15'd0, mem_read}, 16'd0);
        end

        // STI: reset asserted asynchronously during ACCESS
        valid_in = 1; ctrl_mem_write = 1; ctrl_indirect = 1; mar_in = 16'h6003;
        tick();
        idle_inputs();
        mem_resp = 1; mem_rdata = 16'h7001;
        tick();
        mem_resp = 0;
        #1;
        chk("sti acc wr", {15'd0, mem_write}, 16'd1);
        chk("sti acc addr", mem_address, 16'h7000);
        #2;
        reset = 1;    // mid-cycle, away from any clock edge
        #1;
        chk("sti rst wr", {15'd0, mem_write}, 16'd0);
        chk("sti rst addr", mem_address, 16'd0);
        chk("sti rst stall_count", stall_count, 16'd0);
        chk("sti rst addr_out", addr_out, 16'd0);
        tick();
        reset = 0;
        mem_resp = 1;   // late response, must be ignored
        #1;
        chk("late resp wb", {15'd0, mem_wb_load}, 16'd0);
        chk("late resp wr", {15'd0, mem_write}, 16'd0);
        tick();
        mem_resp = 0;
        #1;
        chk("late resp stall_count", stall_count, 16'd0);

        // Stall saturation: read held without a response
        valid_in = 1; ctrl_mem_read = 1; mar_in = 16'h0100;
        tick();
        idle_inputs();
        repeat (70000) @(posedge clk);
        #1;
        chk("sat stall_count", stall_count, 16'hFFFF);
        chk("sat rd held", {15'd0, mem_read}, 16'd1);
        chk("sat addr held", mem_address, 16'h0100);
        mem_resp = 1;
        #1;
        chk("sat done wb", {15'd0, mem_wb_load}, 16'd1);
        tick();
        mem_resp = 0;
        #1;
        chk("sat count holds", stall_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencing controller for the MEM stage of the pipelined LC-3b, directly upstream of write-back. It drives the memory handshake for loads, stores, byte accesses and two-access indirect ops (LDI/STI). It stalls the upstream pipeline while an access is outstanding and pulses the MEM/WB latch load when the instruction completes. It also produces the effective address that write-back uses for byte-lane selection.

## Interface
Parameters:
- none

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  EX/MEM holds a valid instruction
- ctrl_mem_read  in  1  instruction reads memory (LDR/LDB/LDI)
- ctrl_mem_write  in  1  instruction writes memory (STR/STB/STI)
- ctrl_indirect  in  1  pointer fetch precedes the data access
- ctrl_byte  in  1  byte-wide data access
- mar_in  in  16  address from EX/MEM
- mem_rdata  in  16  memory read data
- mem_resp  in  1  memory access complete, single-cycle pulse
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_byte_enable  out  2  {hi, lo} lane enables
- mem_address  out  16  word-aligned access address
- addr_out  out  16  final effective address (unaligned), to MEM/WB
- stall  out  1  hold IF/ID/EX and EX/MEM
- mem_wb_load  out  1  load MEM/WB this cycle
- stall_count  out  16  saturating count of stalled cycles

## Operation
- Memory op: valid_in & (ctrl_mem_read | ctrl_mem_write). If both are set, it is treated as a write.
- The internal addr_reg is captured from mar_in in IDLE when a memory op is detected. addr_out = addr_reg.
- The controller latches the mode bits (write, indirect, byte) in IDLE. It ignores ctrl_* changes afterwards.
- FSM states: IDLE, IND_RD, ACCESS.
- IDLE, no memory op: mem_wb_load = valid_in, stall = 0. The state stays IDLE.
- IDLE, memory op: stall = 1, mem_wb_load = 0. Next state is IND_RD if indirect, else ACCESS.
- IND_RD: mem_read = 1, byte_enable = 2'b11, stall = 1. On mem_resp, addr_reg ← mem_rdata and the next state is ACCESS.
- ACCESS: mem_read = !write, mem_write = write. Byte enables:
  - word: 2'b11
  - byte: addr_reg[0] ? 2'b10 : 2'b01
- ACCESS without mem_resp: stall = 1.
- ACCESS with mem_resp: stall = 0, mem_wb_load = 1, next state IDLE.
- mem_address = {addr_reg[15:1], 1'b0} in IND_RD and ACCESS, and 16'h0 in IDLE.
- stall_count increments every cycle that stall = 1 and holds at 16'hFFFF.
- An unaligned word address is silently aligned through mem_address. addr_out keeps bit 0.

## Timing
- Reset values: state = IDLE, addr_reg = 0, stall_count = 0.
- All outputs are 0 during reset, except mem_wb_load, which follows the IDLE rule above once reset deasserts.
- Reset is asynchronous. Asserting it mid-access drops mem_read/mem_write immediately and abandons the access. A late mem_resp arriving in IDLE is ignored.
- Non-memory instruction: zero latency, with mem_wb_load combinational in the same cycle.
- Direct access: 1 detect cycle + N ACCESS cycles, where N ≥ 1 and mem_resp arrives in the Nth. Total stall cycles = N.
- Indirect access: 1 detect cycle + M IND_RD cycles + N ACCESS cycles.
- Requests stay asserted and stable until mem_resp, including address and enables.
- mem_resp outside IND_RD/ACCESS has no effect.
- The next instruction is evaluated in IDLE on the cycle after completion.

## Structure
- lc3b_types gains:
  - `lc3b_mem_state` enum {IDLE, IND_RD, ACCESS}
  - `lc3b_word` (16-bit) typedef, if not already present
  - byte-enable constants BE_WORD, BE_LO, BE_HI
- One natural sub-module: `sat_counter` (width parameter, inc, clear), used for stall_count.
- FSM: next-state and output logic in one combinational block, with registered state/addr_reg.

## Test plan
- Reset: assert reset with mem_resp toggling → all outputs 0, stall_count 0. After release, an idle bus with valid_in=0 gives mem_wb_load 0.
- ALU op: valid_in=1, no mem ctrl → mem_wb_load=1 and stall=0 in the same cycle, mem_read/mem_write 0.
- LDR: mar_in=0x3001, word, mem_resp on the 3rd ACCESS cycle.
  - mem_address=0x3000, byte_enable=11, mem_read high 3 cycles.
  - mem_wb_load on the resp cycle, addr_out=0x3001, stall_count=3.
- STB: mar_in=0x4005, byte, immediate resp → mem_write=1, byte_enable=10, mem_address=0x4004, mem_wb_load one cycle later.
- LDI: mar_in=0x2000, first resp with mem_rdata=0x5A5B.
  - IND_RD reads at 0x2000.
  - ACCESS reads at 0x5A5A, addr_out=0x5A5B.
  - mem_wb_load only after the second resp.
- Reset mid-ACCESS, then stall saturation:
  - Assert reset during an STI ACCESS → mem_write falls asynchronously, state IDLE.
  - Separately, hold a read with no resp for 70000 cycles → stall_count=0xFFFF.
